if_id: RTL and testbench

IF_ID -- requirements
Module: IF_ID

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/if_id_hazard_detect.sv | 17 +
 rtl/if_id.sv | 99 +++++++++
 tb/tb_if_id.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: instruction field positions, the nop encoding
// and the saturating counter helper used by the fetch/decode boundary.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO         = 5'd0;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/if_id_hazard_detect.sv
// Load-use hazard comparison for the instruction sitting in ID; purely
// combinational. The rt field is compared for every opcode, which is safe.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       raw_hazard
);

    assign raw_hazard = ex_mem_read & id_valid & (ex_rt != REG_ZERO) &
                        ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/if_id.sv
// Fetch PC register and IF/ID pipeline register with load-use stall,
// branch-redirect flush and saturating stall/flush event counters.
module if_id
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_Instr,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        MEM_PCSrc,
    input  logic [31:0] MEM_BranchTarget,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC4,
    output logic [31:0] ID_Order,
    output logic        ID_Valid,
    output logic        ID_Stall,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    logic        raw_hazard;
    logic [31:0] pc_reg,    pc_next;
    logic [31:0] order_reg, order_next;
    logic [31:0] pc4_reg,   pc4_next;
    logic        valid_reg, valid_next;
    logic [1:0]  cnt_inc;

    hazard_detect u_hazard_detect (
        .ex_mem_read (EX_MemRead),
        .ex_rt       (EX_Rt),
        .id_valid    (valid_reg),
        .id_rs       (order_reg[RS_MSB:RS_LSB]),
        .id_rt       (order_reg[RT_MSB:RT_LSB]),
        .raw_hazard  (raw_hazard)
    );

    // A redirect flushes ID anyway, so it suppresses the stall.
    assign ID_Stall = raw_hazard & ~MEM_PCSrc;

    always_comb begin
        pc_next    = pc_reg;
        order_next = order_reg;
        pc4_next   = pc4_reg;
        valid_next = valid_reg;
        if (MEM_PCSrc) begin
            pc_next    = MEM_BranchTarget;
            order_next = NOP_INSTR;
            pc4_next   = 32'h0;
            valid_next = 1'b0;
        end else if (!ID_Stall) begin
            pc_next    = pc_reg + 32'd4;
            order_next = IF_Instr;
            pc4_next   = pc_reg + 32'd4;
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg    <= RESET_PC;
            order_reg <= NOP_INSTR;
            pc4_reg   <= 32'h0;
            valid_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            order_reg <= order_next;
            pc4_reg   <= pc4_next;
            valid_reg <= valid_next;
        end
    end

    // Counter 0 tracks stall cycles, counter 1 tracks redirect cycles.
    assign cnt_inc = {MEM_PCSrc, ID_Stall};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    cnt_reg <= 16'h0;
                else if (cnt_inc[gi])
                    cnt_reg <= sat_inc(cnt_reg);
            end
        end
    endgenerate

    assign IF_PC      = pc_reg;
    assign ID_PC4     = pc4_reg;
    assign ID_Order   = order_reg;
    assign ID_Valid   = valid_reg;
    assign StallCount = g_cnt[0].cnt_reg;
    assign FlushCount = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_if_id.sv
// Scoreboard bench for if_id: a behavioural model queues the expected state
// per edge; directed scenarios plus a short random run are compared against it.
module tb_if_id;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_Instr;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        MEM_PCSrc;
    logic [31:0] MEM_BranchTarget;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC4;
    logic [31:0] ID_Order;
    logic        ID_Valid;
    logic        ID_Stall;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    always #5 clk = ~clk;

    if_id #(.RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .IF_Instr         (IF_Instr),
        .EX_MemRead       (EX_MemRead),
        .EX_Rt            (EX_Rt),
        .MEM_PCSrc        (MEM_PCSrc),
        .MEM_BranchTarget (MEM_BranchTarget),
        .IF_PC            (IF_PC),
        .ID_PC4           (ID_PC4),
        .ID_Order         (ID_Order),
        .ID_Valid         (ID_Valid),
        .ID_Stall         (ID_Stall),
        .StallCount       (StallCount),
        .FlushCount       (FlushCount)
    );

    // Instruction memory: 64 words, address bits [7:2]
    logic [31:0] mem [64];
    assign IF_Instr = mem[IF_PC[7:2]];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] order;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_pc, m_order, m_pc4;
    logic        m_valid;
    logic [15:0] m_sc, m_fc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_stall();
        logic hit;
        hit = (EX_Rt == m_order[25:21]) || (EX_Rt == m_order[20:16]);
        return EX_MemRead && m_valid && (EX_Rt != 5'd0) && hit && !MEM_PCSrc;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_order = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_sc = 16'h0; m_fc = 16'h0;
    endtask

    task automatic model_edge(input logic st);
        if (st && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        if (MEM_PCSrc && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        if (MEM_PCSrc) begin
            m_pc = MEM_BranchTarget; m_order = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_order = mem[m_pc[7:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_state(input exp_t e);
        check("if_pc",       IF_PC,      e.pc);
        check("id_order",    ID_Order,   e.order);
        check("id_pc4",      ID_PC4,     e.pc4);
        check("id_valid",    {31'h0, ID_Valid}, {31'h0, e.valid});
        check("stall_count", {16'h0, StallCount}, {16'h0, e.sc});
        check("flush_count", {16'h0, FlushCount}, {16'h0, e.fc});
    endtask

    // One transaction: drive inputs, check the combinational stall,
    // queue the expected post-edge state, clock, then pop and compare.
    task automatic step(input logic mr, input logic [4:0] rt, input logic ps, input logic [31:0] tgt);
        logic st;
        exp_t e;
        EX_MemRead = mr; EX_Rt = rt; MEM_PCSrc = ps; MEM_BranchTarget = tgt;
        #1;
        st = model_stall();
        check("id_stall", {31'h0, ID_Stall}, {31'h0, st});
        model_edge(st);
        sb_q.push_back('{m_pc, m_order, m_pc4, m_valid, m_sc, m_fc});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare_state(e);
        $display("txn mr=%b rt=%0d ps=%b stall=%b -> pc=%h order=%h pc4=%h valid=%b sc=%0d fc=%0d",
                 mr, rt, ps, st, IF_PC, ID_Order, ID_PC4, ID_Valid, StallCount, FlushCount);
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_state('{m_pc, m_order, m_pc4, m_valid, m_sc, m_fc});
        check("rst_stall", {31'h0, ID_Stall}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        EX_MemRead = 1'b0; MEM_PCSrc = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = {6'h23, 5'(i + 1), 5'(i + 17), 16'(i * 4 + 1)};
        mem[9] = {6'h00, 5'd0, 5'd0, 16'h1234};

        rst = 1'b1; EX_MemRead = 1'b0; EX_Rt = 5'd0;
        MEM_PCSrc = 1'b0; MEM_BranchTarget = 32'h0;
        @(posedge clk); #1;

        // Reset with a hazard-shaped input: stall must stay low
        EX_MemRead = 1'b1; EX_Rt = 5'd1;
        assert_reset();

        // Sequential fetch
        repeat (4) step(1'b0, 5'd0, 1'b0, 32'h0);
        check("seq_pc",    IF_PC,    32'h10);
        check("seq_pc4",   ID_PC4,   32'h10);
        check("seq_order", ID_Order, mem[3]);

        // Load-use on rs=8 (mem[7])
        repeat (4) step(1'b0, 5'd0, 1'b0, 32'h0);
        step(1'b1, 5'd8, 1'b0, 32'h0);
        check("lu_pc_held",    IF_PC,    32'h20);
        check("lu_order_held", ID_Order, mem[7]);
        check("lu_sc",         {16'h0, StallCount}, 32'h1);
        step(1'b0, 5'd8, 1'b0, 32'h0);
        check("lu_resume", ID_Order, mem[8]);

        // $zero never stalls; rt-only match stalls
        step(1'b0, 5'd0, 1'b0, 32'h0);
        step(1'b1, 5'd0, 1'b0, 32'h0);
        step(1'b1, 5'd27, 1'b0, 32'h0);
        check("rt_stall_sc", {16'h0, StallCount}, 32'h2);

        // Redirect while hazard is active
        step(1'b1, 5'd27, 1'b1, 32'h100);
        check("redir_pc",    IF_PC,    32'h100);
        check("redir_order", ID_Order, 32'h0);
        check("redir_fc",    {16'h0, FlushCount}, 32'h1);
        step(1'b1, 5'd27, 1'b0, 32'h0);

        // Random mix, including unaligned targets
        for (int n = 0; n < 40; n++) begin
            logic [4:0] rt;
            case ($urandom_range(0, 3))
                0: rt = m_order[25:21];
                1: rt = m_order[20:16];
                2: rt = 5'd0;
                default: rt = 5'($urandom_range(0, 31));
            endcase
            step(1'($urandom_range(0, 1)), rt, ($urandom_range(0, 7) == 0),
                 32'($urandom_range(0, 255)));
        end

        // PC wrap
        step(1'b0, 5'd0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 5'd0, 1'b0, 32'h0);
        check("wrap_pc",  IF_PC,  32'h0);
        check("wrap_pc4", ID_PC4, 32'h0);

        // Reset mid-redirect from IF_PC=0x40
        step(1'b0, 5'd0, 1'b1, 32'h40);
        check("pre_rst_pc", IF_PC, 32'h40);
        MEM_PCSrc = 1'b1; MEM_BranchTarget = 32'h80;
        assert_reset();
        step(1'b0, 5'd0, 1'b0, 32'h0);
        check("post_rst_order", ID_Order, mem[0]);
        check("post_rst_pc",    IF_PC,    32'h4);

        // Reset mid-stall, then saturate the stall counter
        EX_MemRead = 1'b1; EX_Rt = 5'd1;
        assert_reset();
        step(1'b0, 5'd0, 1'b0, 32'h0);
        EX_MemRead = 1'b1; EX_Rt = 5'd1; MEM_PCSrc = 1'b0;
        for (int n = 0; n < 65535; n++) begin
            #1;
            model_edge(model_stall());
            @(posedge clk);
        end
        #1;
        check("sat_reach", {16'h0, StallCount}, 32'hFFFF);
        repeat (3) step(1'b1, 5'd1, 1'b0, 32'h0);
        check("sat_hold", {16'h0, StallCount}, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
